// File: rtl/fas_pkg.sv
// Shared constants, state type and bin-word helpers for the FAS frequency analyzer.
package fas_pkg;

    localparam int NPTS   = 16;
    localparam int DW     = 16;
    localparam int MAG_W  = 32;
    localparam int WORD_W = 2 * DW;
    localparam int IDX_W  = $clog2(NPTS);

    typedef enum logic {
        IDLE,
        SCAN
    } fa_state_t;

    // Bin words carry the real part in the upper half, imaginary in the lower half.
    function automatic logic signed [DW-1:0] re_of(input logic [WORD_W-1:0] word);
        return signed'(word[WORD_W-1:DW]);
    endfunction

    function automatic logic signed [DW-1:0] im_of(input logic [WORD_W-1:0] word);
        return signed'(word[DW-1:0]);
    endfunction

endpackage

// File: rtl/fas_freq_analyzer_if.sv
// FFT-frame input bus and result outputs of the frequency analyzer.
interface fas_freq_analyzer_if;
    import fas_pkg::*;

    logic              fft_valid;
    logic [WORD_W-1:0] fft_d [NPTS];
    logic              done;
    logic [IDX_W-1:0]  freq;
    logic              busy;
    logic              overflow;

    modport master (
        output fft_valid, fft_d,
        input  done, freq, busy, overflow
    );

    modport slave (
        input  fft_valid, fft_d,
        output done, freq, busy, overflow
    );

endinterface

// File: rtl/fas_mag_sq.sv
// Registered squared-magnitude unit: mag = re*re + im*im, one cycle latency, index tag travels along.
module fas_mag_sq
    import fas_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IDX_W-1:0]     in_idx,
    input  logic signed [DW-1:0] re,
    input  logic signed [DW-1:0] im,
    output logic                 out_valid,
    output logic [IDX_W-1:0]     out_idx,
    output logic [MAG_W-1:0]     mag
);

    logic signed [MAG_W-1:0] re_sq;
    logic signed [MAG_W-1:0] im_sq;
    logic [MAG_W-1:0]        mag_sum;

    // Both squares are non-negative and at most 2^30, so the unsigned sum tops out at 2^31.
    assign re_sq   = MAG_W'(re) * MAG_W'(re);
    assign im_sq   = MAG_W'(im) * MAG_W'(im);
    assign mag_sum = unsigned'(re_sq) + unsigned'(im_sq);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            mag       <= '0;
        end else begin
            out_valid <= in_valid;
            out_idx   <= in_idx;
            mag       <= mag_sum;
        end
    end

endmodule

// File: rtl/fas_freq_analyzer.sv
// Frequency analyzer: captures 16-bin FFT frames (with a one-deep shadow buffer),
// squares each bin and reports the index of the strongest bin with a done pulse.
module fas_freq_analyzer
    import fas_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fas_freq_analyzer_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NPTS - 1);

    fa_state_t        state, next_state;
    logic [IDX_W-1:0] bin_cnt, next_bin_cnt;
    logic             pend, next_pend;
    logic             load_in;
    logic             move_shadow;
    logic             load_shadow;
    logic             drop;

    logic [WORD_W-1:0] active_buf [NPTS];
    logic [WORD_W-1:0] shadow_buf [NPTS];
    logic [WORD_W-1:0] cur_word;

    logic             mag_valid;
    logic [IDX_W-1:0] mag_idx;
    logic [MAG_W-1:0] mag;
    logic             take;
    logic [MAG_W-1:0] best_mag;
    logic [IDX_W-1:0] best_idx;

    logic             done_r;
    logic [IDX_W-1:0] freq_r;
    logic             busy_r;
    logic             overflow_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bin_cnt <= '0;
            pend    <= 1'b0;
        end else begin
            state   <= next_state;
            bin_cnt <= next_bin_cnt;
            pend    <= next_pend;
        end
    end

    // A frame arriving during the last bin restarts the scan directly when the shadow is
    // empty; if the shadow is full it is being emptied this cycle, so the frame refills it.
    always_comb begin
        next_state   = state;
        next_bin_cnt = bin_cnt;
        next_pend    = pend;
        load_in      = 1'b0;
        move_shadow  = 1'b0;
        load_shadow  = 1'b0;
        drop         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.fft_valid) begin
                    load_in      = 1'b1;
                    next_state   = SCAN;
                    next_bin_cnt = '0;
                end
            end
            SCAN: begin
                if (bin_cnt == LAST_BIN) begin
                    next_bin_cnt = '0;
                    if (pend) begin
                        move_shadow = 1'b1;
                        if (bus.fft_valid) begin
                            load_shadow = 1'b1;
                        end else begin
                            next_pend = 1'b0;
                        end
                    end else if (bus.fft_valid) begin
                        load_in = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    next_bin_cnt = bin_cnt + 1'b1;
                    if (bus.fft_valid) begin
                        if (pend) begin
                            drop = 1'b1;
                        end else begin
                            load_shadow = 1'b1;
                            next_pend   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                next_state   = IDLE;
                next_bin_cnt = '0;
                next_pend    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_in) begin
            active_buf <= bus.fft_d;
        end else if (move_shadow) begin
            active_buf <= shadow_buf;
        end
        if (load_shadow) begin
            shadow_buf <= bus.fft_d;
        end
    end

    assign cur_word = active_buf[bin_cnt];

    fas_mag_sq u_mag_sq (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state == SCAN),
        .in_idx    (bin_cnt),
        .re        (re_of(cur_word)),
        .im        (im_of(cur_word)),
        .out_valid (mag_valid),
        .out_idx   (mag_idx),
        .mag       (mag)
    );

    // Strict greater-than keeps the lowest index on ties; bin 0 always seeds the search.
    assign take = (mag_idx == '0) || (mag > best_mag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_mag   <= '0;
            best_idx   <= '0;
            done_r     <= 1'b0;
            freq_r     <= '0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (mag_valid && take) begin
                best_mag <= mag;
                best_idx <= mag_idx;
            end
            done_r <= mag_valid && (mag_idx == LAST_BIN);
            if (mag_valid && (mag_idx == LAST_BIN)) begin
                freq_r <= take ? mag_idx : best_idx;
            end
            busy_r     <= (state == SCAN);
            overflow_r <= overflow_r | drop;
        end
    end

    assign bus.done     = done_r;
    assign bus.freq     = freq_r;
    assign bus.busy     = busy_r;
    assign bus.overflow = overflow_r;

endmodule
